// File: rtl/pipe_regfile_if.sv
// Decode/writeback bundle for pipe_regfile: read ports, writeback, issue and hazard status.
interface pipe_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic              rs_use;
  logic              rt_use;
  logic [DATA_W-1:0] qa;
  logic [DATA_W-1:0] qb;
  logic              wreg;
  logic [ADDR_W-1:0] wn;
  logic [DATA_W-1:0] wd;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_dest;
  logic              stall;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    output rs, rt, rs_use, rt_use, wreg, wn, wd, iss_valid, iss_dest,
    input  qa, qb, stall, busy_cnt
  );

  modport slave (
    input  rs, rt, rs_use, rt_use, wreg, wn, wd, iss_valid, iss_dest,
    output qa, qb, stall, busy_cnt
  );
endinterface

// File: rtl/pipe_regfile.sv
// Register file with busy-bit scoreboard; combinational reads, RAW stall generation.
// Define PIPE_REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module pipe_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  pipe_regfile_if.slave  rf
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;
  logic [ADDR_W:0]   busy_cnt_q;
  logic [ADDR_W:0]   cnt_nxt;
  logic              fwd_a;
  logic              fwd_b;
  logic              hazard_a;
  logic              hazard_b;

`ifdef PIPE_REGFILE_BYPASS_EN
  assign fwd_a = rf.wreg && (rf.wn != '0) && (rf.wn == rf.rs);
  assign fwd_b = rf.wreg && (rf.wn != '0) && (rf.wn == rf.rt);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  assign rf.qa = fwd_a ? rf.wd : ((rf.rs == '0) ? '0 : regs[rf.rs]);
  assign rf.qb = fwd_b ? rf.wd : ((rf.rt == '0) ? '0 : regs[rf.rt]);

  assign hazard_a = busy[rf.rs] & ~fwd_a;
  assign hazard_b = busy[rf.rt] & ~fwd_b;
  assign rf.stall = (rf.rs_use & hazard_a) | (rf.rt_use & hazard_b);

  // Clear before set so a same-cycle reissue to the retiring register stays busy.
  always_comb begin
    busy_nxt = busy;
    if (rf.wreg)
      busy_nxt[rf.wn] = 1'b0;
    if (rf.iss_valid && !rf.stall && (rf.iss_dest != '0))
      busy_nxt[rf.iss_dest] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++)
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      busy       <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (rf.wreg && (rf.wn != '0))
        regs[rf.wn] <= rf.wd;
      busy       <= busy_nxt;
      busy_cnt_q <= cnt_nxt;
    end
  end

  assign rf.busy_cnt = busy_cnt_q;
endmodule
